// File: rtl/fft_frame_source.sv
// Producer for the FFT core's AXI4-Stream input: config beat, then one frame of
// real ADC samples converted to signed complex, buffered by a FWFT skid FIFO.
`timescale 1ns/1ps
module fft_frame_source #(
  parameter int unsigned LOGS_FFT_LEN = 13,
  parameter int unsigned INPUT_WIDTH  = 10,
  parameter int unsigned SAMPLE_WIDTH = 12,
  parameter int unsigned DATAIN_WIDTH = 16,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic                      i_aclk,
  input  logic                      i_areset,
  input  logic                      i_start,
  input  logic                      i_fft_mode,
  input  logic [SAMPLE_WIDTH-1:0]   i_sample,
  input  logic                      i_sample_vld,
  output logic                      o_axi4s_cfg_tvalid,
  output logic                      o_axi4s_cfg_tdata,
  output logic                      o_axi4s_data_tvalid,
  output logic [2*DATAIN_WIDTH-1:0] o_axi4s_data_tdata,
  output logic                      o_axi4s_data_tlast,
  input  logic                      i_axi4s_data_tready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow
);

  localparam int unsigned FRAME_N = 1 << LOGS_FFT_LEN;
  localparam int unsigned CNT_W   = LOGS_FFT_LEN + 1;
  localparam int unsigned DEPTH   = 1 << FIFO_AW;
  localparam int unsigned PTR_W   = FIFO_AW + 1;

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_N);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_N - 1);
  localparam logic [PTR_W-1:0] FULL_LVL  = PTR_W'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CFG     = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]             state, state_nxt;
  logic                   mode_q, mode_nxt;
  logic                   cfg_vld_q, cfg_vld_nxt;
  logic                   busy_q, busy_nxt;
  logic                   done_q, done_nxt;
  logic                   ovf_q, ovf_nxt;

  logic                   in_vld;
  logic [INPUT_WIDTH-1:0] in_data;
  logic [INPUT_WIDTH-1:0] conv;
  logic [INPUT_WIDTH-1:0] mem [DEPTH];
  logic [INPUT_WIDTH-1:0] rd_word;
  logic [DATAIN_WIDTH-1:0] re_ext;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       cap_cnt, send_cnt;

  logic fifo_empty, fifo_full, out_active, data_tvalid;
  logic pop, wr_due, push, drop, last_hs, start_acc;
  logic unused_sample_bits;

  // Offset binary to two's complement: invert MSB, keep the top INPUT_WIDTH bits.
  assign conv = {~i_sample[SAMPLE_WIDTH-1], i_sample[SAMPLE_WIDTH-2 -: INPUT_WIDTH-1]};
  assign unused_sample_bits = ^i_sample;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = ((wr_ptr - rd_ptr) == FULL_LVL);
  assign out_active  = (state == S_CAPTURE) || (state == S_DRAIN);
  assign data_tvalid = out_active && !fifo_empty;
  assign pop         = data_tvalid && i_axi4s_data_tready;
  assign wr_due      = in_vld && (state == S_CAPTURE) && (cap_cnt != FRAME_LEN);
  assign push        = wr_due && (!fifo_full || pop);
  assign drop        = wr_due && fifo_full && !pop;
  assign last_hs     = pop && (send_cnt == LAST_IDX);
  assign start_acc   = i_start && (state == S_IDLE);

  assign rd_word = mem[rd_ptr[FIFO_AW-1:0]];
  assign re_ext  = DATAIN_WIDTH'($signed(rd_word));

  assign o_axi4s_data_tvalid = data_tvalid;
  assign o_axi4s_data_tdata  = data_tvalid ? {{DATAIN_WIDTH{1'b0}}, re_ext} : '0;
  assign o_axi4s_data_tlast  = data_tvalid && (send_cnt == LAST_IDX);
  assign o_axi4s_cfg_tvalid  = cfg_vld_q;
  assign o_axi4s_cfg_tdata   = mode_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_overflow          = ovf_q;

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // The final beat can handshake while still in CAPTURE, so both states check it.
  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode_q;
    cfg_vld_nxt = 1'b0;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    ovf_nxt     = ovf_q || drop;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt   = S_CFG;
          mode_nxt    = i_fft_mode;
          cfg_vld_nxt = 1'b1;
          busy_nxt    = 1'b1;
          ovf_nxt     = 1'b0;
        end
      end
      S_CFG:     state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (last_hs) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (cap_cnt == FRAME_LEN) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_hs) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      mode_q    <= 1'b0;
      cfg_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      mode_q    <= mode_nxt;
      cfg_vld_q <= cfg_vld_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  // Input stage, FIFO pointers and frame counters.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      in_vld   <= 1'b0;
      in_data  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cap_cnt  <= '0;
      send_cnt <= '0;
    end else begin
      in_vld <= i_sample_vld && (state == S_CAPTURE);
      if (i_sample_vld) in_data <= conv;
      if (start_acc) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        cap_cnt  <= '0;
        send_cnt <= '0;
      end else begin
        if (push) begin
          wr_ptr  <= wr_ptr + PTR_W'(1);
          cap_cnt <= cap_cnt + CNT_W'(1);
        end
        if (pop) begin
          rd_ptr   <= rd_ptr + PTR_W'(1);
          send_cnt <= send_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_fft_frame_source.sv
// Scoreboard bench for fft_frame_source with an 8-sample frame and a 4-deep FIFO.
`timescale 1ns/1ps
module tb_fft_frame_source;

  localparam int unsigned LOGN = 3;
  localparam int unsigned IW   = 10;
  localparam int unsigned SW   = 12;
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 2;
  localparam int          NB   = 8;

  logic            clk;
  logic            rst;
  logic            i_start, i_fft_mode, i_sample_vld, tready;
  logic [SW-1:0]   i_sample;
  logic            cfg_tvalid, cfg_tdata, tvalid, tlast, busy, done, ovf;
  logic [2*DW-1:0] tdata;

  fft_frame_source #(
    .LOGS_FFT_LEN(LOGN), .INPUT_WIDTH(IW), .SAMPLE_WIDTH(SW),
    .DATAIN_WIDTH(DW), .FIFO_AW(AW)
  ) dut (
    .i_aclk(clk), .i_areset(rst), .i_start(i_start), .i_fft_mode(i_fft_mode),
    .i_sample(i_sample), .i_sample_vld(i_sample_vld),
    .o_axi4s_cfg_tvalid(cfg_tvalid), .o_axi4s_cfg_tdata(cfg_tdata),
    .o_axi4s_data_tvalid(tvalid), .o_axi4s_data_tdata(tdata),
    .o_axi4s_data_tlast(tlast), .i_axi4s_data_tready(tready),
    .o_busy(busy), .o_done(done), .o_overflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] exp_w;
  logic [2*DW-1:0] prev_data;
  logic            prev_last;
  int  beats_seen = 0, cfg_cnt = 0, pushed = 0;
  bit  frame_done = 0, pend_done = 0, stalled_prev = 0, mon_en = 0, allow_drop = 0;
  logic exp_mode = 1'b0;

  logic [SW-1:0] vals1 [NB] = '{12'h000, 12'h800, 12'hFFF, 12'h7FF, 12'h123, 12'hABC, 12'h456, 12'hDEF};
  logic [SW-1:0] vals2 [NB] = '{12'h3A5, 12'hC01, 12'h0F0, 12'hF0F, 12'h555, 12'hAAA, 12'h801, 12'h7FE};

  // Offset-binary sample minus midscale, scaled down by the dropped LSBs.
  function automatic logic [2*DW-1:0] model(input logic [SW-1:0] s);
    int v;
    logic [DW-1:0] re;
    v  = (int'(s) - 2048) >>> 2;
    re = DW'(v);
    return {{DW{1'b0}}, re};
  endfunction

  // Output monitor: scoreboard pop, tlast position, stall stability, done pulse, cfg beats.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (done !== pend_done) begin
        failures++;
        $display("FAIL done_pulse: got %b want %b at %0t", done, pend_done, $time);
      end
      if (done === 1'b1) frame_done = 1'b1;
      pend_done = 1'b0;
      if (cfg_tvalid === 1'b1) begin
        cfg_cnt++;
        checks++;
        if (cfg_tdata !== exp_mode) begin
          failures++;
          $display("FAIL cfg_tdata: got %b want %b", cfg_tdata, exp_mode);
        end
      end
      if (stalled_prev) begin
        checks++;
        if ({tvalid, tlast, tdata} !== {1'b1, prev_last, prev_data}) begin
          failures++;
          $display("FAIL stall_hold: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                   tvalid, tlast, tdata, prev_last, prev_data);
        end
      end
      if (tvalid === 1'b1) begin
        checks++;
        if (tlast !== 1'(beats_seen == NB-1)) begin
          failures++;
          $display("FAIL tlast: got %b want %b at beat %0d", tlast, (beats_seen == NB-1), beats_seen);
        end
        if (tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL beat_extra: got %h want no beat", tdata);
          end else if (allow_drop) begin
            while (exp_q.size() > 0 && exp_q[0] !== tdata) void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL beat_order: got %h want a later captured sample", tdata);
            end else void'(exp_q.pop_front());
          end else begin
            exp_w = exp_q.pop_front();
            if (tdata !== exp_w) begin
              failures++;
              $display("FAIL beat_data: got %h want %h at beat %0d", tdata, exp_w, beats_seen);
            end
          end
          beats_seen++;
          if (tlast === 1'b1) pend_done = 1'b1;
        end
      end
      stalled_prev = (tvalid === 1'b1) && !tready;
      prev_data    = tdata;
      prev_last    = tlast;
    end else begin
      pend_done    = 1'b0;
      stalled_prev = 1'b0;
    end
  end

  task automatic begin_frame(input logic mode);
    frame_done = 0; beats_seen = 0; cfg_cnt = 0; pushed = 0;
    exp_q.delete();
    exp_mode = mode;
    @(posedge clk); #1;
    i_start = 1'b1; i_fft_mode = mode;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic put_sample(input logic [SW-1:0] s);
    i_sample_vld = 1'b1;
    i_sample     = s;
    if (allow_drop || pushed < NB) begin
      exp_q.push_back(model(s));
      pushed++;
    end
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 400 && !frame_done; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 0; i_fft_mode = 0; i_sample = '0; i_sample_vld = 0; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tvalid, tlast, tdata, cfg_tvalid, cfg_tdata, busy, done, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h cv=%b cd=%b b=%b dn=%b o=%b want all 0",
               tvalid, tlast, tdata, cfg_tvalid, cfg_tdata, busy, done, ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({tvalid, cfg_tvalid, busy, done, ovf} !== 5'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b want 00000", {tvalid, cfg_tvalid, busy, done, ovf});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    begin_frame(1'b1);
    checks++;
    if ({cfg_tvalid, cfg_tdata, busy, ovf} !== 4'b1110) begin
      failures++;
      $display("FAIL cfg_cycle: got cv=%b cd=%b b=%b o=%b want 1110", cfg_tvalid, cfg_tdata, busy, ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL cfg_one_cycle: got %b want 0", cfg_tvalid);
    end
    for (int k = 0; k < NB; k++) begin
      put_sample(vals1[k]);
      if (k == 1) begin
        checks++;
        if (tvalid !== 1'b0) begin
          failures++;
          $display("FAIL latency_early: got tvalid %b want 0", tvalid);
        end
      end
      if (k == 2) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h0000_FE00) begin
          failures++;
          $display("FAIL latency_first: got v=%b d=%h want v=1 d=0000fe00", tvalid, tdata);
        end
      end
      if (k == 3) begin
        checks++;
        if (tdata !== 32'h0000_0000) begin
          failures++;
          $display("FAIL midscale_beat: got %h want 00000000", tdata);
        end
      end
      @(posedge clk); #1;
    end
    i_sample_vld = 1'b0;
    wait_frame();
    checks++;
    if (!frame_done || beats_seen != NB || cfg_cnt != 1 || busy !== 1'b0 || ovf !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_end: got done=%b beats=%0d cfg=%0d busy=%b ovf=%b left=%0d want 1 8 1 0 0 0",
               frame_done, beats_seen, cfg_cnt, busy, ovf, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    allow_drop = 1'b1;
    begin_frame(1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      put_sample(12'((k + 100) << 2));
      if (k == 3)  tready = 1'b0;
      if (k == 23) tready = 1'b1;
      @(posedge clk); #1;
    end
    i_sample_vld = 1'b0;
    tready = 1'b1;
    wait_frame();
    checks++;
    if (!frame_done || beats_seen != NB || ovf !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overflow_end: got done=%b beats=%0d ovf=%b busy=%b want 1 8 1 0",
               frame_done, beats_seen, ovf, busy);
    end
    allow_drop = 1'b0;
  endtask

  task automatic test_toggle();
    begin_frame(1'b0);
    checks++;
    if ({cfg_tvalid, cfg_tdata, ovf} !== 3'b100) begin
      failures++;
      $display("FAIL start_clears_ovf: got cv=%b cd=%b o=%b want 100", cfg_tvalid, cfg_tdata, ovf);
    end
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 200 && !frame_done; i++) begin
          tready = ~tready;
          @(posedge clk); #1;
        end
      end
      begin
        for (int k = 0; k < NB; k++) begin
          put_sample(vals2[k]);
          @(posedge clk); #1;
          i_sample_vld = 1'b0;
          @(posedge clk); #1;
          @(posedge clk); #1;
        end
      end
    join
    tready = 1'b1;
    wait_frame();
    checks++;
    if (!frame_done || beats_seen != NB || ovf !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL toggle_end: got done=%b beats=%0d ovf=%b left=%0d want 1 8 0 0",
               frame_done, beats_seen, ovf, exp_q.size());
    end
  endtask

  task automatic test_start_ignored();
    begin_frame(1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < NB; k++) begin
      put_sample(vals2[NB-1-k]);
      i_start = (k == 4);
      i_fft_mode = 1'b0;
      @(posedge clk); #1;
    end
    i_sample_vld = 1'b0;
    i_start = 1'b0;
    wait_frame();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (!frame_done || beats_seen != NB || cfg_cnt != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL start_ignored: got done=%b beats=%0d cfg=%0d busy=%b left=%0d want 1 8 1 0 0",
               frame_done, beats_seen, cfg_cnt, busy, exp_q.size());
    end
  endtask

  task automatic test_extra_samples();
    begin_frame(1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      put_sample(12'(k * 341));
      @(posedge clk); #1;
    end
    i_sample_vld = 1'b0;
    wait_frame();
    checks++;
    if (!frame_done || beats_seen != NB || ovf !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL extra_samples: got done=%b beats=%0d ovf=%b left=%0d want 1 8 0 0",
               frame_done, beats_seen, ovf, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    begin_frame(1'b1);
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < NB; k++) begin
          put_sample(vals1[k]);
          @(posedge clk); #1;
        end
        i_sample_vld = 1'b0;
      end
      begin
        for (int i = 0; i < 100 && beats_seen < 4; i++) @(negedge clk);
        checks++;
        if (beats_seen < 4) begin
          failures++;
          $display("FAIL reset_reach_beat4: got %0d beats want 4", beats_seen);
        end
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({tvalid, tlast, tdata, cfg_tvalid, cfg_tdata, busy, done, ovf} !== '0) begin
          failures++;
          $display("FAIL async_reset: got v=%b l=%b d=%h cv=%b cd=%b b=%b dn=%b o=%b want all 0",
                   tvalid, tlast, tdata, cfg_tvalid, cfg_tdata, busy, done, ovf);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    begin_frame(1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < NB; k++) begin
      put_sample(vals2[k]);
      @(posedge clk); #1;
    end
    i_sample_vld = 1'b0;
    wait_frame();
    checks++;
    if (!frame_done || beats_seen != NB || cfg_cnt != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL after_reset_frame: got done=%b beats=%0d cfg=%0d left=%0d want 1 8 1 0",
               frame_done, beats_seen, cfg_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_toggle();
    test_start_ignored();
    test_extra_samples();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
